spectrum_line_buffer: RTL and testbench



---
 rtl/spectrum_line_buffer.sv | 164 ++++++++++++++++
 tb/tb_spectrum_line_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_line_buffer.sv
// Ping-pong peak-hold spectrum line buffer with ready/done readout handshake.
// Optional build macro SPECTRUM_LINE_BUFFER_AVG_EN selects rounded exponential averaging instead of peak-hold.
module spectrum_line_buffer #(
  parameter int MEMORYWIDTH     = 10,
  parameter int DATAWIDTH       = 16,
  parameter int LINES_PER_FRAME = 8
) (
  input  logic                   i_lvds_bitClk,
  input  logic                   i_rst,
  input  logic                   i_mem_sampleStrobe,
  input  logic [MEMORYWIDTH-1:0] i_frameCounter,
  input  logic [DATAWIDTH-1:0]   i_sample,
  input  logic [MEMORYWIDTH-1:0] i_rd_addr,
  output logic [DATAWIDTH-1:0]   o_rd_data,
  output logic                   o_frameReady,
  input  logic                   i_rd_done,
  output logic                   o_overrun,
  output logic [7:0]             o_overrunCount
);

  localparam int DEPTH = 1 << MEMORYWIDTH;
  localparam logic [MEMORYWIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [7:0]             LINES_LAST = 8'(LINES_PER_FRAME);

  typedef enum logic {SYNC, ACCUM} state_t;

  state_t                 state, state_nxt;
  logic                   accept;
  logic                   wr_bank;
  logic [7:0]             line_idx;
  logic                   frame_ready;
  logic                   overrun;
  logic [7:0]             overrun_cnt;
  logic                   frame_end;
  logic                   ready_eff;

  logic                   vld_p1;
  logic                   first_p1;
  logic [MEMORYWIDTH-1:0] addr_p1;
  logic [DATAWIDTH-1:0]   sample_p1;
  logic [DATAWIDTH-1:0]   old_p1;
  logic [DATAWIDTH-1:0]   wval_p1;

  logic [DATAWIDTH-1:0]   bank0 [DEPTH];
  logic [DATAWIDTH-1:0]   bank1 [DEPTH];
  logic [MEMORYWIDTH-1:0] raddr0, raddr1;
  logic [DATAWIDTH-1:0]   q0, q1;
  logic                   rd_sel;

`ifdef SPECTRUM_LINE_BUFFER_AVG_EN
  function automatic logic [DATAWIDTH-1:0] combine(input logic [DATAWIDTH-1:0] old_val,
                                                   input logic [DATAWIDTH-1:0] new_val);
    logic [DATAWIDTH:0] sum;
    sum = {1'b0, old_val} + {1'b0, new_val} + (DATAWIDTH+1)'(1);
    return DATAWIDTH'(sum >> 1);
  endfunction
`else
  function automatic logic [DATAWIDTH-1:0] combine(input logic [DATAWIDTH-1:0] old_val,
                                                   input logic [DATAWIDTH-1:0] new_val);
    return (new_val > old_val) ? new_val : old_val;
  endfunction
`endif

  // SYNC waits for the start of a line before any strobe is accepted
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      SYNC: begin
        if (i_mem_sampleStrobe && (i_frameCounter == '0)) begin
          accept    = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        accept = i_mem_sampleStrobe;
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge i_lvds_bitClk) begin
    if (i_rst) state <= SYNC;
    else       state <= state_nxt;
  end

  // Stage p1: strobe captured, RAM read of the write bank in flight
  always_ff @(posedge i_lvds_bitClk) begin
    if (i_rst) vld_p1 <= 1'b0;
    else       vld_p1 <= accept;
  end

  always_ff @(posedge i_lvds_bitClk) begin
    addr_p1   <= i_frameCounter;
    sample_p1 <= i_sample;
    first_p1  <= (line_idx == 8'd0);
  end

  // Each bank has one read port, shared between RMW and readout by role
  always_comb begin
    raddr0 = wr_bank ? i_rd_addr : i_frameCounter;
    raddr1 = wr_bank ? i_frameCounter : i_rd_addr;
  end

  always_ff @(posedge i_lvds_bitClk) begin
    if (i_rst) begin
      q0     <= '0;
      q1     <= '0;
      rd_sel <= 1'b1;
    end else begin
      q0     <= bank0[raddr0];
      q1     <= bank1[raddr1];
      rd_sel <= ~wr_bank;
    end
  end

  assign o_rd_data = rd_sel ? q1 : q0;

  // Stage p1 -> commit: line 0 overwrites, later lines combine with the stored bin
  always_comb begin
    old_p1  = wr_bank ? q1 : q0;
    wval_p1 = first_p1 ? sample_p1 : combine(old_p1, sample_p1);
  end

  always_ff @(posedge i_lvds_bitClk) begin
    if (vld_p1 && !i_rst && !wr_bank) bank0[addr_p1] <= wval_p1;
    if (vld_p1 && !i_rst &&  wr_bank) bank1[addr_p1] <= wval_p1;
  end

  // A done pulse arriving with frame end is honoured first, so the swap still happens
  always_comb begin
    frame_end = (state == ACCUM) && (line_idx == LINES_LAST);
    ready_eff = frame_ready && !i_rd_done;
  end

  always_ff @(posedge i_lvds_bitClk) begin
    if (i_rst) begin
      wr_bank     <= 1'b0;
      line_idx    <= 8'd0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      overrun <= 1'b0;
      if (i_rd_done) frame_ready <= 1'b0;
      if (vld_p1 && (addr_p1 == LAST_ADDR)) line_idx <= line_idx + 8'd1;
      if (frame_end) begin
        line_idx <= 8'd0;
        if (!ready_eff) begin
          wr_bank     <= ~wr_bank;
          frame_ready <= 1'b1;
        end else begin
          overrun <= 1'b1;
          if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end
      end
    end
  end

  assign o_frameReady   = frame_ready;
  assign o_overrun      = overrun;
  assign o_overrunCount = overrun_cnt;

endmodule

// File: tb/tb_spectrum_line_buffer.sv
// Directed bench for spectrum_line_buffer: 16-bin banks, two lines per frame.
module tb_spectrum_line_buffer;

  localparam int MW  = 4;
  localparam int DW  = 16;
  localparam int LPF = 2;
`ifdef SPECTRUM_LINE_BUFFER_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          strobe = 1'b0;
  logic [MW-1:0] fc = '0;
  logic [DW-1:0] smp = '0;
  logic [MW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          ready;
  logic          rd_done = 1'b0;
  logic          ovr;
  logic [7:0]    ovr_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          frame;
    logic [3:0]  addr;
    logic [15:0] peak;
    logic [15:0] avg;
  } rd_vec_t;

  rd_vec_t vecs[$];

  always #5 clk = ~clk;

  spectrum_line_buffer #(
    .MEMORYWIDTH(MW),
    .DATAWIDTH(DW),
    .LINES_PER_FRAME(LPF)
  ) dut (
    .i_lvds_bitClk(clk),
    .i_rst(rst),
    .i_mem_sampleStrobe(strobe),
    .i_frameCounter(fc),
    .i_sample(smp),
    .i_rd_addr(rd_addr),
    .o_rd_data(rd_data),
    .o_frameReady(ready),
    .i_rd_done(rd_done),
    .o_overrun(ovr),
    .o_overrunCount(ovr_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int f, input int a, input int p, input int v);
    rd_vec_t r;
    r.frame = f;
    r.addr  = 4'(a);
    r.peak  = 16'(p);
    r.avg   = 16'(v);
    vecs.push_back(r);
  endtask

  task automatic send(input int addr, input int sample);
    @(negedge clk);
    strobe = 1'b1;
    fc     = MW'(addr);
    smp    = DW'(sample);
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Full line with sample = mul*addr + off; the last strobe is tracked cycle by cycle
  task automatic line(input int mul, input int off, input bit done_at_end,
                      input bit rdy_before, input bit rdy_after, input bit ovr_exp,
                      input string tag);
    for (int k = 0; k < 15; k++) send(k, mul * k + off);
    @(negedge clk);
    strobe = 1'b1;
    fc     = MW'(15);
    smp    = DW'(mul * 15 + off);
    @(negedge clk);
    strobe = 1'b0;
    check({tag, "_rdy_c1"}, 32'(ready), 32'(rdy_before));
    @(negedge clk);
    check({tag, "_rdy_c2"}, 32'(ready), 32'(rdy_before));
    if (done_at_end) rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    check({tag, "_rdy_c3"}, 32'(ready), 32'(rdy_after));
    check({tag, "_ovr_c3"}, 32'(ovr), 32'(ovr_exp));
    @(negedge clk);
    check({tag, "_ovr_c4"}, 32'(ovr), 32'd0);
  endtask

  task automatic read_frame(input int f);
    foreach (vecs[i]) begin
      if (vecs[i].frame == f) begin
        @(negedge clk);
        rd_addr = vecs[i].addr;
        @(negedge clk);
        check($sformatf("rd_f%0d_a%0d", f, vecs[i].addr), 32'(rd_data),
              32'(AVG ? vecs[i].avg : vecs[i].peak));
      end
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // frame 1: line k, line 15-k
    add_vec(1, 0, 15, 8);  add_vec(1, 3, 12, 8);  add_vec(1, 7, 8, 8);
    add_vec(1, 8, 8, 8);   add_vec(1, 10, 10, 8); add_vec(1, 15, 15, 8);
    // frame 2: line 2k, line 30-2k
    add_vec(2, 0, 30, 15); add_vec(2, 3, 24, 15); add_vec(2, 7, 16, 15);
    add_vec(2, 8, 16, 15); add_vec(2, 10, 20, 15); add_vec(2, 15, 30, 15);
    // frame 3: partial line of 50s, restart, line k, line 9
    add_vec(3, 0, 9, 5);   add_vec(3, 3, 9, 6);   add_vec(3, 7, 9, 8);
    add_vec(3, 8, 9, 9);   add_vec(3, 10, 10, 10); add_vec(3, 12, 12, 11);
    add_vec(3, 15, 15, 12);
    // frame 4: line 40, line 44
    add_vec(4, 0, 44, 42); add_vec(4, 9, 44, 42);
    // frame 5: line 100, line 201
    add_vec(5, 0, 201, 151); add_vec(5, 7, 201, 151); add_vec(5, 15, 201, 151);

    repeat (3) @(negedge clk);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_ready",   32'(ready),   32'd0);
    check("rst_ovr",     32'(ovr),     32'd0);
    check("rst_ovr_cnt", 32'(ovr_cnt), 32'd0);
    rst = 1'b0;

    // strobes before a line start are ignored, then two lines fill frame 1
    send(5, 99);
    send(6, 99);
    line(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "f1_l0");
    line(-1, 15, 1'b0, 1'b0, 1'b1, 1'b0, "f1_l1");
    read_frame(1);

    // reader holds the bank: next frame is dropped
    line(0, 7, 1'b0, 1'b1, 1'b1, 1'b0, "ovr_l0");
    line(0, 3, 1'b0, 1'b1, 1'b1, 1'b1, "ovr_l1");
    check("ovr_cnt_1", 32'(ovr_cnt), 32'd1);
    read_frame(1);

    // done coincides with frame end: swap wins, ready stays high
    line(2, 0, 1'b0, 1'b1, 1'b1, 1'b0, "f2_l0");
    line(-2, 30, 1'b1, 1'b1, 1'b1, 1'b0, "f2_l1");
    check("ovr_cnt_still_1", 32'(ovr_cnt), 32'd1);
    read_frame(2);

    // release, then a stray done while not ready
    pulse_done();
    check("done_clears_ready", 32'(ready), 32'd0);
    pulse_done();
    check("stray_done_ready", 32'(ready), 32'd0);

    // partial line then restart at 0: only full lines count
    for (int k = 0; k < 8; k++) send(k, 50);
    line(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "f3_l0");
    line(0, 9, 1'b0, 1'b0, 1'b1, 1'b0, "f3_l1");
    read_frame(3);

    // reset in the middle of a line
    @(negedge clk);
    rd_addr = 4'd15;
    @(negedge clk);
    check("pre_rst_rd_data", 32'(rd_data), AVG ? 32'd12 : 32'd15);
    for (int k = 0; k < 5; k++) send(k, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rd_data", 32'(rd_data), 32'd0);
    check("mid_rst_ready",   32'(ready),   32'd0);
    check("mid_rst_ovr",     32'(ovr),     32'd0);
    check("mid_rst_ovr_cnt", 32'(ovr_cnt), 32'd0);
    rst = 1'b0;
    send(3, 16'hFFFF);
    send(15, 16'hFFFF);
    line(0, 40, 1'b0, 1'b0, 1'b0, 1'b0, "f4_l0");
    line(0, 44, 1'b0, 1'b0, 1'b1, 1'b0, "f4_l1");
    read_frame(4);

    // constant lines 100 then 201
    pulse_done();
    check("f5_release", 32'(ready), 32'd0);
    line(0, 100, 1'b0, 1'b0, 1'b0, 1'b0, "f5_l0");
    line(0, 201, 1'b0, 1'b0, 1'b1, 1'b0, "f5_l1");
    read_frame(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
